// File: rtl/lstm_state_wb.sv
// Packs per-unit ct/ht bytes four lanes per word and writes them back to the state SRAM.
// Optional saturated-ht counter output sat_cnt enabled by LSTM_STATE_WB_SATCNT_EN.
module lstm_state_wb #(
    parameter int unsigned HIDDEN_SIZE = 64,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned ADDR_W      = 8,
    parameter logic [7:0]  PAD_CT      = 8'd128,
    parameter logic [7:0]  PAD_HT      = 8'd128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              step_start,
    input  logic [ADDR_W-1:0] ct_base,
    input  logic [ADDR_W-1:0] ht_base,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_ct,
    input  logic [7:0]        in_ht,
    output logic              mem_wr_en,
    input  logic              mem_wr_ready,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [31:0]       mem_wr_data,
    output logic              mem_wr_sel,
    output logic              busy,
    output logic              step_done
`ifdef LSTM_STATE_WB_SATCNT_EN
    ,
    output logic [7:0]        sat_cnt
`endif
);

    localparam int unsigned WORDS = (HIDDEN_SIZE + 3) / 4;
    localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [31:0] PAD_WORD_CT = {4{PAD_CT}};
    localparam logic [31:0] PAD_WORD_HT = {4{PAD_HT}};

    typedef struct packed {
        logic [31:0]      ct;
        logic [31:0]      ht;
        logic [IDX_W-1:0] idx;
    } entry_t;

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;
    typedef enum logic [1:0] {W_IDLE, W_CT, W_HT} wstate_t;

    state_t            state;
    wstate_t           wstate;
    logic [ADDR_W-1:0] ct_base_r;
    logic [ADDR_W-1:0] ht_base_r;
    logic [7:0]        unit_cnt;
    logic [1:0]        lane;
    logic [IDX_W-1:0]  word_idx;
    logic [31:0]       ct_pack;
    logic [31:0]       ht_pack;

    entry_t            fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  fifo_cnt;

    logic              fifo_full;
    logic              fifo_empty;
    logic              accept;
    logic              last_unit;
    logic              push;
    logic              pop;
    logic [31:0]       ct_word_c;
    logic [31:0]       ht_word_c;
    entry_t            push_entry;
    entry_t            head;
    entry_t            next_head;

    assign fifo_full  = (fifo_cnt == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (fifo_cnt == '0);
    assign in_ready   = (state == ACTIVE) && !fifo_full;
    assign busy       = (state != IDLE);
    assign accept     = in_valid && in_ready;
    assign last_unit  = (unit_cnt == 8'(HIDDEN_SIZE - 1));
    assign push       = accept && ((lane == 2'd3) || last_unit);
    assign pop        = (wstate == W_HT) && mem_wr_ready;
    assign head       = fifo_mem[rd_ptr];
    assign next_head  = fifo_mem[rd_ptr + PTR_W'(1)];

    // Current pack registers with the incoming byte merged into its lane
    always_comb begin
        ct_word_c = ct_pack;
        ht_word_c = ht_pack;
        ct_word_c[{lane, 3'b000} +: 8] = in_ct;
        ht_word_c[{lane, 3'b000} +: 8] = in_ht;
        push_entry = '{ct: ct_word_c, ht: ht_word_c, idx: word_idx};
    end

    // Control FSM, lane packing and step completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ct_base_r <= '0;
            ht_base_r <= '0;
            unit_cnt  <= '0;
            lane      <= '0;
            word_idx  <= '0;
            ct_pack   <= PAD_WORD_CT;
            ht_pack   <= PAD_WORD_HT;
            step_done <= 1'b0;
        end else begin
            step_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (step_start) begin
                        state     <= ACTIVE;
                        ct_base_r <= ct_base;
                        ht_base_r <= ht_base;
                        unit_cnt  <= '0;
                        lane      <= '0;
                        word_idx  <= '0;
                        ct_pack   <= PAD_WORD_CT;
                        ht_pack   <= PAD_WORD_HT;
                    end
                end
                ACTIVE: begin
                    if (accept) begin
                        unit_cnt <= unit_cnt + 8'd1;
                        if (push) begin
                            ct_pack  <= PAD_WORD_CT;
                            ht_pack  <= PAD_WORD_HT;
                            lane     <= '0;
                            word_idx <= word_idx + IDX_W'(1);
                        end else begin
                            ct_pack <= ct_word_c;
                            ht_pack <= ht_word_c;
                            lane    <= lane + 2'd1;
                        end
                        if (last_unit) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (fifo_empty && (wstate == W_IDLE)) begin
                        state     <= IDLE;
                        step_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Packed-word FIFO storage; contents are qualified by the pointers
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Write FSM: each FIFO entry becomes a ct write followed by an ht write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wstate      <= W_IDLE;
            mem_wr_en   <= 1'b0;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
            mem_wr_sel  <= 1'b0;
        end else begin
            case (wstate)
                W_IDLE: begin
                    if (!fifo_empty) begin
                        wstate      <= W_CT;
                        mem_wr_en   <= 1'b1;
                        mem_wr_addr <= ct_base_r + ADDR_W'(head.idx);
                        mem_wr_data <= head.ct;
                        mem_wr_sel  <= 1'b0;
                    end
                end
                W_CT: begin
                    if (mem_wr_ready) begin
                        wstate      <= W_HT;
                        mem_wr_addr <= ht_base_r + ADDR_W'(head.idx);
                        mem_wr_data <= head.ht;
                        mem_wr_sel  <= 1'b1;
                    end
                end
                W_HT: begin
                    if (mem_wr_ready) begin
                        if (fifo_cnt > CNT_W'(1)) begin
                            wstate      <= W_CT;
                            mem_wr_addr <= ct_base_r + ADDR_W'(next_head.idx);
                            mem_wr_data <= next_head.ct;
                            mem_wr_sel  <= 1'b0;
                        end else begin
                            wstate      <= W_IDLE;
                            mem_wr_en   <= 1'b0;
                            mem_wr_addr <= '0;
                            mem_wr_data <= '0;
                            mem_wr_sel  <= 1'b0;
                        end
                    end
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

`ifdef LSTM_STATE_WB_SATCNT_EN
    // Saturating count of accepted ht bytes pinned at either rail
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_cnt <= '0;
        end else if ((state == IDLE) && step_start) begin
            sat_cnt <= '0;
        end else if (accept && ((in_ht == 8'd0) || (in_ht == 8'hFF)) && (sat_cnt != 8'hFF)) begin
            sat_cnt <= sat_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lstm_state_wb.sv
// Directed bench for lstm_state_wb: three instances (8 units, 5 units, 16 units with a 2-deep FIFO).
module tb_lstm_state_wb;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  start;
    logic [7:0]  ct_base;
    logic [7:0]  ht_base;
    logic        in_valid;
    logic [7:0]  in_ct;
    logic [7:0]  in_ht;
    logic        mem_wr_ready;

    logic        rdy   [3];
    logic        wen   [3];
    logic        wsel  [3];
    logic        bsy   [3];
    logic        done  [3];
    logic [7:0]  waddr [3];
    logic [31:0] wdata [3];
`ifdef LSTM_STATE_WB_SATCNT_EN
    logic [7:0]  sat   [3];
`endif

    int          total = 0;
    int          bad = 0;
    int          cur = 0;
    int          done_cnt [3];
    logic [40:0] wq [$];
    logic [7:0]  ct_v [16];
    logic [7:0]  ht_v [16];
    int          acc;
    int          acc2;

    always #5 clk = ~clk;

    lstm_state_wb #(.HIDDEN_SIZE(8), .FIFO_DEPTH(4), .ADDR_W(8)) dut_a (
        .clk(clk), .rst(rst), .step_start(start[0]), .ct_base(ct_base), .ht_base(ht_base),
        .in_valid(in_valid), .in_ready(rdy[0]), .in_ct(in_ct), .in_ht(in_ht),
        .mem_wr_en(wen[0]), .mem_wr_ready(mem_wr_ready), .mem_wr_addr(waddr[0]),
        .mem_wr_data(wdata[0]), .mem_wr_sel(wsel[0]), .busy(bsy[0]), .step_done(done[0])
`ifdef LSTM_STATE_WB_SATCNT_EN
        , .sat_cnt(sat[0])
`endif
    );

    lstm_state_wb #(.HIDDEN_SIZE(5), .FIFO_DEPTH(4), .ADDR_W(8)) dut_b (
        .clk(clk), .rst(rst), .step_start(start[1]), .ct_base(ct_base), .ht_base(ht_base),
        .in_valid(in_valid), .in_ready(rdy[1]), .in_ct(in_ct), .in_ht(in_ht),
        .mem_wr_en(wen[1]), .mem_wr_ready(mem_wr_ready), .mem_wr_addr(waddr[1]),
        .mem_wr_data(wdata[1]), .mem_wr_sel(wsel[1]), .busy(bsy[1]), .step_done(done[1])
`ifdef LSTM_STATE_WB_SATCNT_EN
        , .sat_cnt(sat[1])
`endif
    );

    lstm_state_wb #(.HIDDEN_SIZE(16), .FIFO_DEPTH(2), .ADDR_W(8)) dut_c (
        .clk(clk), .rst(rst), .step_start(start[2]), .ct_base(ct_base), .ht_base(ht_base),
        .in_valid(in_valid), .in_ready(rdy[2]), .in_ct(in_ct), .in_ht(in_ht),
        .mem_wr_en(wen[2]), .mem_wr_ready(mem_wr_ready), .mem_wr_addr(waddr[2]),
        .mem_wr_data(wdata[2]), .mem_wr_sel(wsel[2]), .busy(bsy[2]), .step_done(done[2])
`ifdef LSTM_STATE_WB_SATCNT_EN
        , .sat_cnt(sat[2])
`endif
    );

    // Completed writes and step_done pulses of the selected instance
    always @(negedge clk) begin
        if (wen[cur] && mem_wr_ready) begin
            wq.push_back({wsel[cur], waddr[cur], wdata[cur]});
        end
        for (int i = 0; i < 3; i++) begin
            if (done[i]) begin
                done_cnt[i] = done_cnt[i] + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_wr(input int i, input logic [7:0] a, input logic [31:0] d, input logic s);
        if (i < wq.size()) begin
            check($sformatf("wr%0d_dut%0d", i, cur), 64'(wq[i]), 64'({s, a, d}));
        end else begin
            check($sformatf("wr%0d_missing_dut%0d", i, cur), 64'(wq.size()), 64'(i + 1));
        end
    endtask

    task automatic start_step(input int idx, input logic [7:0] cb, input logic [7:0] hb);
        @(posedge clk); #1;
        cur = idx;
        wq.delete();
        done_cnt[idx] = 0;
        ct_base = cb;
        ht_base = hb;
        start[idx] = 1'b1;
        @(posedge clk); #1;
        start[idx] = 1'b0;
    endtask

    // Offer units first..n-1 for at most max_cyc cycles; acc_o = units accepted so far
    task automatic feed(input int first, input int n, input int max_cyc, output int acc_o);
        int a;
        a = first;
        for (int c = 0; c < max_cyc && a < n; c++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_ct = ct_v[a];
            in_ht = ht_v[a];
            @(negedge clk);
            if (rdy[cur]) begin
                a++;
            end
        end
        if (a == n) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
        acc_o = a;
    endtask

    task automatic wait_done(input string tag);
        for (int c = 0; c < 300 && done_cnt[cur] == 0; c++) begin
            @(posedge clk); #1;
        end
        repeat (4) @(posedge clk);
        #1;
        check({tag, "_done_pulses"}, 64'(done_cnt[cur]), 64'd1);
        check({tag, "_busy_after"}, 64'(bsy[cur]), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        start = '0;
        ct_base = '0;
        ht_base = '0;
        in_valid = 1'b0;
        in_ct = '0;
        in_ht = '0;
        mem_wr_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_ready%0d", i), 64'(rdy[i]), 64'd0);
            check($sformatf("rst_wen%0d", i), 64'(wen[i]), 64'd0);
            check($sformatf("rst_busy%0d", i), 64'(bsy[i]), 64'd0);
            check($sformatf("rst_done%0d", i), 64'(done[i]), 64'd0);
            check($sformatf("rst_bus%0d", i), 64'({wsel[i], waddr[i], wdata[i]}), 64'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic step: 8 units, two full words
        for (int u = 0; u < 16; u++) begin
            ct_v[u] = 8'(u + 1);
            ht_v[u] = 8'(u + 8'h81);
        end
        start_step(0, 8'h10, 8'h40);
        check("basic_busy", 64'(bsy[0]), 64'd1);
        feed(0, 8, 100, acc);
        check("basic_accepted", 64'(acc), 64'd8);
        wait_done("basic");
        check("basic_nwr", 64'(wq.size()), 64'd4);
        check_wr(0, 8'h10, 32'h04030201, 1'b0);
        check_wr(1, 8'h40, 32'h84838281, 1'b1);
        check_wr(2, 8'h11, 32'h08070605, 1'b0);
        check_wr(3, 8'h41, 32'h88878685, 1'b1);

        // Address wrap: ct region starts at the top of the address space
        start_step(0, 8'hFF, 8'h7F);
        feed(0, 8, 100, acc);
        wait_done("wrap");
        check_wr(0, 8'hFF, 32'h04030201, 1'b0);
        check_wr(1, 8'h7F, 32'h84838281, 1'b1);
        check_wr(2, 8'h00, 32'h08070605, 1'b0);
        check_wr(3, 8'h80, 32'h88878685, 1'b1);

        // Partial word: 5 units, upper three lanes padded
        for (int u = 0; u < 16; u++) begin
            ct_v[u] = 8'(u + 8'h11);
            ht_v[u] = 8'(u + 8'h21);
        end
        start_step(1, 8'h20, 8'h30);
        feed(0, 5, 100, acc);
        wait_done("partial");
        check("partial_nwr", 64'(wq.size()), 64'd4);
        check_wr(0, 8'h20, 32'h14131211, 1'b0);
        check_wr(1, 8'h30, 32'h24232221, 1'b1);
        check_wr(2, 8'h21, 32'h80808015, 1'b0);
        check_wr(3, 8'h31, 32'h80808025, 1'b1);

        // Backpressure: 2-deep FIFO, memory stalled for 40 cycles
        for (int u = 0; u < 16; u++) begin
            ct_v[u] = 8'(u);
            ht_v[u] = 8'(u + 8'h80);
        end
        @(posedge clk); #1;
        mem_wr_ready = 1'b0;
        start_step(2, 8'h00, 8'h80);
        feed(0, 16, 20, acc);
        check("bp_mid_wen", 64'(wen[2]), 64'd1);
        check("bp_mid_bus", 64'({wsel[2], waddr[2], wdata[2]}), 64'({1'b0, 8'h00, 32'h03020100}));
        @(posedge clk); #1;
        ct_base = 8'h55;
        start[2] = 1'b1;
        @(posedge clk); #1;
        start[2] = 1'b0;
        feed(acc, 16, 20, acc2);
        check("bp_accepted_stalled", 64'(acc2), 64'd8);
        check("bp_ready_low", 64'(rdy[2]), 64'd0);
        check("bp_end_bus", 64'({wen[2], wsel[2], waddr[2], wdata[2]}), 64'({1'b1, 1'b0, 8'h00, 32'h03020100}));
        check("bp_no_writes_yet", 64'(wq.size()), 64'd0);
        @(posedge clk); #1;
        mem_wr_ready = 1'b1;
        feed(acc2, 16, 200, acc);
        check("bp_accepted_total", 64'(acc), 64'd16);
        wait_done("bp");
        check("bp_nwr", 64'(wq.size()), 64'd8);
        check_wr(0, 8'h00, 32'h03020100, 1'b0);
        check_wr(1, 8'h80, 32'h83828180, 1'b1);
        check_wr(2, 8'h01, 32'h07060504, 1'b0);
        check_wr(3, 8'h81, 32'h87868584, 1'b1);
        check_wr(4, 8'h02, 32'h0b0a0908, 1'b0);
        check_wr(5, 8'h82, 32'h8b8a8988, 1'b1);
        check_wr(6, 8'h03, 32'h0f0e0d0c, 1'b0);
        check_wr(7, 8'h83, 32'h8f8e8d8c, 1'b1);

        // Reset after 3 accepted units discards the partial word
        for (int u = 0; u < 16; u++) begin
            ct_v[u] = 8'(u + 1);
            ht_v[u] = 8'(u + 8'h81);
        end
        start_step(0, 8'h10, 8'h40);
        feed(0, 3, 50, acc);
        check("rstmid_accepted", 64'(acc), 64'd3);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("rstmid_busy", 64'(bsy[0]), 64'd0);
        check("rstmid_ready", 64'(rdy[0]), 64'd0);
        check("rstmid_bus", 64'({wen[0], wsel[0], waddr[0], wdata[0]}), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("rstmid_no_writes", 64'(wq.size()), 64'd0);
        check("rstmid_no_done", 64'(done_cnt[0]), 64'd0);
        for (int u = 0; u < 16; u++) begin
            ct_v[u] = 8'(u + 8'h31);
            ht_v[u] = 8'(u + 8'hA1);
        end
        start_step(0, 8'h10, 8'h40);
        feed(0, 8, 100, acc);
        wait_done("after_rst");
        check_wr(0, 8'h10, 32'h34333231, 1'b0);
        check_wr(1, 8'h40, 32'hA4A3A2A1, 1'b1);
        check_wr(2, 8'h11, 32'h38373635, 1'b0);
        check_wr(3, 8'h41, 32'hA8A7A6A5, 1'b1);

`ifdef LSTM_STATE_WB_SATCNT_EN
        // Saturated-ht counter over one 5-unit step
        ht_v[0] = 8'h00;
        ht_v[1] = 8'hFF;
        ht_v[2] = 8'h7F;
        ht_v[3] = 8'hFF;
        ht_v[4] = 8'h10;
        start_step(1, 8'h00, 8'h08);
        feed(0, 5, 100, acc);
        wait_done("sat");
        check("sat_cnt", 64'(sat[1]), 64'd3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lstm_state_wb.md
Name: lstm_state_wb

Overview:
- Downstream consumer of the B-direction TMQ stage.
- Takes one saturated 8-bit ct byte and one ht byte per hidden unit, packs them four units per 32-bit word, buffers the words and writes them to the state SRAM.
- Each completed word produces one ct write and one ht write.
- Pulses step_done once the whole timestep has been written back, so the controller can start the next timestep.

Parameters:
- HIDDEN_SIZE, 64: hidden units per timestep, range 1..255.
- FIFO_DEPTH, 4: packed-word FIFO entries, power of 2, at least 2.
- ADDR_W, 8: state memory word-address width.
- PAD_CT, 8'd128: pad byte for unused ct lanes (state zero point).
- PAD_HT, 8'd128: pad byte for unused ht lanes (data zero point).

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: asynchronous, active-high reset.
- step_start, input, 1: begin a timestep; accepted only in IDLE.
- ct_base, input, ADDR_W: ct region base word address; sampled on accepted step_start.
- ht_base, input, ADDR_W: ht region base word address; sampled on accepted step_start.
- in_valid, input, 1: ct/ht byte pair is valid.
- in_ready, output, 1: block can accept a pair.
- in_ct, input, 8: saturated ct byte (B_sat_ct_TMQ).
- in_ht, input, 8: saturated ht byte (B_sat_ht_TMQ).
- mem_wr_en, output, 1: write request.
- mem_wr_ready, input, 1: memory accepts the request this cycle.
- mem_wr_addr, output, ADDR_W: write address.
- mem_wr_data, output, 32: write data.
- mem_wr_sel, output, 1: 0 = ct write, 1 = ht write.
- busy, output, 1: high whenever the FSM is not in IDLE.
- step_done, output, 1: one-cycle pulse when the timestep is fully written.

Behaviour:
- Reset values:
  - All outputs 0.
  - FSM in IDLE; FIFO empty; lane and word counters 0; pack registers hold the PAD values.
- Control FSM:
  - IDLE -> ACTIVE on step_start. ct_base and ht_base are latched; unit_cnt = 0; lane = 0.
  - ACTIVE -> DRAIN when the pair for unit HIDDEN_SIZE-1 is accepted.
  - DRAIN -> IDLE when the FIFO is empty and the write FSM is idle. step_done pulses in the cycle IDLE is entered.
  - step_start outside IDLE is ignored.
- Input handshake:
  - A transfer occurs on (in_valid && in_ready) at a rising edge.
  - in_ready = (state == ACTIVE) && !fifo_full, using the registered full flag only (no same-cycle pop pass-through).
- Packing:
  - Unit u lands in lane u%4, bits [8*(u%4)+7 : 8*(u%4)]; little-endian.
  - On the lane-3 accept, or the last-unit accept, the entry {ct_word, ht_word, word_idx} is pushed into the FIFO at that same edge.
  - Lanes not yet written in that word carry PAD_CT / PAD_HT.
  - After the push, the pack registers are reloaded with the pad values.
  - word_idx counts 0..ceil(HIDDEN_SIZE/4)-1.
- Write FSM (W_IDLE, W_CT, W_HT):
  - W_IDLE -> W_CT when the FIFO is not empty. First mem_wr_en is asserted the cycle after the push.
  - W_CT drives: addr = ct_base + word_idx, data = ct_word, sel = 0. Holds until mem_wr_ready, then -> W_HT.
  - W_HT drives: addr = ht_base + word_idx, data = ht_word, sel = 1. On mem_wr_ready the FIFO is popped; next state is W_CT if another entry is present, else W_IDLE.
  - Address, data and sel are stable while mem_wr_en is high and mem_wr_ready is low.
  - Address addition wraps modulo 2^ADDR_W.
- Simultaneous push and pop in the same cycle:
  - Both take effect; occupancy is unchanged.
  - A full FIFO deasserts in_ready in the following cycle only if it stays full.
- Reset mid-operation:
  - Everything returns to the reset values immediately.
  - A partially packed word is discarded; step_done does not pulse.

Optional Feature:
- Macro: LSTM_STATE_WB_SATCNT_EN.
- When defined:
  - Extra output sat_cnt [7:0], cleared on accepted step_start.
  - It increments, saturating at 255, for each accepted in_ht equal to 8'd0 or 8'd255, i.e. ht saturated by TMQ.
  - It holds its value through IDLE until the next step_start.
- When undefined: the port and the counter logic are absent; all other behaviour is identical.

Test Plan:
- Basic step:
  - Stimulus: HIDDEN_SIZE=8, ct_base=0x10, ht_base=0x40, mem_wr_ready=1; pairs ct=u+1, ht=u+0x81 for u=0..7 back-to-back.
  - Response: writes (0x10, 0x04030201, ct), (0x40, 0x84838281, ht), (0x11, 0x08070605, ct), (0x41, 0x88878685, ht); then one step_done pulse.
- Partial word:
  - Stimulus: HIDDEN_SIZE=5, ct=0x11..0x15.
  - Response: second ct word 0x80808015; second ht word padded with 0x80 in the same three upper lanes.
- Backpressure:
  - Stimulus: FIFO_DEPTH=2, mem_wr_ready=0 for 40 cycles, 16 units offered.
  - Response: in_ready drops after 8 accepted units (2 full entries); address and data held stable; all 8 writes complete in order after mem_wr_ready rises.
- Address wrap:
  - Stimulus: ADDR_W=8, ct_base=0xFF, HIDDEN_SIZE=8.
  - Response: ct writes go to 0xFF, then 0x00.
- Reset mid-step:
  - Stimulus: assert rst after 3 units accepted.
  - Response: outputs 0 and busy=0 immediately, no write and no step_done; a new step after reset starts at word 0.
- LSTM_STATE_WB_SATCNT_EN defined:
  - Stimulus: ht stream 0x00, 0xFF, 0x7F, 0xFF.
  - Response: sat_cnt=3 after the step.
